// File: rtl/tdm_slot_if.sv
// Frame-timing bundle between a TDM serial-port controller and its slot timer.
// The master drives tick and configuration; the slave returns the frame position.
interface tdm_slot_if #(
    parameter int CH_W = 4
);
    logic            bclk_tick;
    logic            enable;
    logic [CH_W-1:0] ch_num;
    logic            slot_width_sel;
    logic [2:0]      valid_word_width;

    logic            active;
    logic            frame_start;
    logic [CH_W-1:0] slot_idx;
    logic [4:0]      bit_idx;
    logic            bit_valid;
    logic            word_last;
    logic [5:0]      valid_word_width_real;
    logic            cfg_err;

    modport master (
        output bclk_tick, enable, ch_num, slot_width_sel, valid_word_width,
        input  active, frame_start, slot_idx, bit_idx, bit_valid, word_last,
               valid_word_width_real, cfg_err
    );

    modport slave (
        input  bclk_tick, enable, ch_num, slot_width_sel, valid_word_width,
        output active, frame_start, slot_idx, bit_idx, bit_valid, word_last,
               valid_word_width_real, cfg_err
    );
endinterface

// File: rtl/tdm_slot_timer.sv
// TDM frame/slot/bit position generator advanced only by serial bit-clock ticks.
//   state | meaning
//   IDLE  | no frame running; waits for a tick with enable to latch config and start
//   RUN   | frame running; config frozen in shadow registers until the next frame start
module tdm_slot_timer #(
    parameter int MAX_CH = 16,
    parameter int CH_W   = $clog2(MAX_CH)
) (
    input  logic        clk,
    input  logic        rst,
    tdm_slot_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] slot_q, slot_d;
    logic [CH_W-1:0] sh_ch_q, sh_ch_d;
    logic [4:0]      bit_q, bit_d;
    logic [4:0]      left_q, left_d;
    logic            sh_sw_q, sh_sw_d;
    logic [5:0]      vwr_q, vwr_d;
    logic            fs_q, fs_d;
    logic            err_q, err_d;
    logic            bv_q, bv_d;
    logic            wl_q, wl_d;

    logic [5:0]      dec_width;
    logic [5:0]      slot_bits_in;
    logic [4:0]      slot_last_in;
    logic [4:0]      slot_last_sh;
    logic            latch;

    always_comb begin
        dec_width = 6'd0;
        case (bus.valid_word_width)
            3'd1:    dec_width = 6'd16;
            3'd2:    dec_width = 6'd20;
            3'd3:    dec_width = 6'd24;
            3'd4:    dec_width = 6'd32;
            default: dec_width = 6'd0;
        endcase
    end

    assign slot_bits_in = bus.slot_width_sel ? 6'd32 : 6'd16;
    assign slot_last_in = bus.slot_width_sel ? 5'd31 : 5'd15;
    assign slot_last_sh = sh_sw_q ? 5'd31 : 5'd15;

    // left_q counts the bits remaining in the current slot; zero marks the slot's last bit.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        left_d  = left_q;
        sh_ch_d = sh_ch_q;
        sh_sw_d = sh_sw_q;
        vwr_d   = vwr_q;
        err_d   = err_q;
        fs_d    = 1'b0;
        latch   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.bclk_tick && bus.enable) begin
                    latch = 1'b1;
                end
            end
            RUN: begin
                if (bus.bclk_tick) begin
                    if (left_q == 5'd0) begin
                        if (slot_q == sh_ch_q) begin
                            if (bus.enable) begin
                                latch = 1'b1;
                            end else begin
                                state_d = IDLE;
                                slot_d  = '0;
                                bit_d   = 5'd0;
                                left_d  = 5'd0;
                            end
                        end else begin
                            slot_d = slot_q + 1'b1;
                            bit_d  = 5'd0;
                            left_d = slot_last_sh;
                        end
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        left_d = left_q - 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            state_d = RUN;
            slot_d  = '0;
            bit_d   = 5'd0;
            left_d  = slot_last_in;
            fs_d    = 1'b1;
            sh_ch_d = bus.ch_num;
            sh_sw_d = bus.slot_width_sel;
            if (dec_width > slot_bits_in) begin
                vwr_d = slot_bits_in;
                err_d = 1'b1;
            end else begin
                vwr_d = dec_width;
            end
        end

        // Qualifiers are computed from next-state values so they register alongside the counters.
        bv_d = (state_d == RUN) && ({1'b0, bit_d} < vwr_d);
        wl_d = (state_d == RUN) && (vwr_d != 6'd0) && ({1'b0, bit_d} == (vwr_d - 6'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            bit_q   <= 5'd0;
            left_q  <= 5'd0;
            sh_ch_q <= '0;
            sh_sw_q <= 1'b0;
            vwr_q   <= 6'd0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
            bv_q    <= 1'b0;
            wl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            left_q  <= left_d;
            sh_ch_q <= sh_ch_d;
            sh_sw_q <= sh_sw_d;
            vwr_q   <= vwr_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
            bv_q    <= bv_d;
            wl_q    <= wl_d;
        end
    end

    assign bus.active                = (state_q == RUN);
    assign bus.frame_start           = fs_q;
    assign bus.slot_idx              = slot_q;
    assign bus.bit_idx               = bit_q;
    assign bus.bit_valid             = bv_q;
    assign bus.word_last             = wl_q;
    assign bus.valid_word_width_real = vwr_q;
    assign bus.cfg_err               = err_q;

endmodule

// File: tb/tb_tdm_slot_timer.sv
// Self-checking bench for tdm_slot_timer: frame-position reference model plus directed
// scenarios with literal expectations, followed by randomized tick/config/reset traffic.
module tb_tdm_slot_timer;
    localparam int MAX_CH = 16;
    localparam int CH_W   = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tdm_slot_if #(.CH_W(CH_W)) bus ();

    tdm_slot_timer #(.MAX_CH(MAX_CH), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int decode(input logic [2:0] code);
        case (code)
            3'd1:    return 16;
            3'd2:    return 20;
            3'd3:    return 24;
            3'd4:    return 32;
            default: return 0;
        endcase
    endfunction

    // Model: a running frame is just a tick position within (ch+1)*slot_bits ticks.
    bit m_run = 0;
    bit m_fs  = 0;
    bit m_err = 0;
    int m_pos = 0;
    int m_ch  = 0;
    int m_sb  = 16;
    int m_w   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_fs = 0; m_err = 0; m_pos = 0; m_ch = 0; m_sb = 16; m_w = 0;
        end else begin
            m_fs = 0;
            if (bus.bclk_tick) begin
                if (m_run && (m_pos + 1 < (m_ch + 1) * m_sb)) begin
                    m_pos++;
                end else if (bus.enable) begin
                    int d;
                    m_run = 1;
                    m_pos = 0;
                    m_fs  = 1;
                    m_ch  = int'(bus.ch_num);
                    m_sb  = bus.slot_width_sel ? 32 : 16;
                    d     = decode(bus.valid_word_width);
                    if (d > m_sb) begin
                        m_w   = m_sb;
                        m_err = 1;
                    end else begin
                        m_w = d;
                    end
                end else begin
                    m_run = 0;
                    m_pos = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int e_bit;
        e_bit = m_pos % m_sb;
        chk("active",      int'(bus.active),      int'(m_run));
        chk("frame_start", int'(bus.frame_start), int'(m_fs));
        chk("slot_idx",    int'(bus.slot_idx),    m_pos / m_sb);
        chk("bit_idx",     int'(bus.bit_idx),     e_bit);
        chk("bit_valid",   int'(bus.bit_valid),   int'(m_run && e_bit < m_w));
        chk("word_last",   int'(bus.word_last),   int'(m_run && m_w != 0 && e_bit == m_w - 1));
        chk("vwr",         int'(bus.valid_word_width_real), m_w);
        chk("cfg_err",     int'(bus.cfg_err),     int'(m_err));
    end

    task automatic tick(input int gap);
        repeat (gap) @(negedge clk);
        bus.bclk_tick = 1'b1;
        @(negedge clk);
        bus.bclk_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setcfg(input int ch, input bit sw, input int code, input bit en);
        bus.ch_num           = CH_W'(ch);
        bus.slot_width_sel   = sw;
        bus.valid_word_width = 3'(code);
        bus.enable           = en;
    endtask

    task automatic pos_is(input string name, input int act_en, input int slot, input int bitn);
        chk({name, "_active"}, int'(bus.active), act_en);
        chk({name, "_slot"},   int'(bus.slot_idx), slot);
        chk({name, "_bit"},    int'(bus.bit_idx), bitn);
    endtask

    initial begin
        rst = 1'b1;
        bus.bclk_tick = 1'b0;
        setcfg(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        pos_is("rst", 0, 0, 0);
        chk("rst_fs",  int'(bus.frame_start), 0);
        chk("rst_vwr", int'(bus.valid_word_width_real), 0);
        chk("rst_err", int'(bus.cfg_err), 0);
        rst = 1'b0;

        // 4 x 32-bit slots, 24-bit words: 128-tick frames.
        setcfg(3, 1, 3, 1);
        tick(3);
        chk("a_fs", int'(bus.frame_start), 1);
        pos_is("a_first", 1, 0, 0);
        chk("a_vwr", int'(bus.valid_word_width_real), 24);
        chk("a_bv0", int'(bus.bit_valid), 1);
        ticks(23);
        chk("a_wl23", int'(bus.word_last), 1);
        chk("a_bv23", int'(bus.bit_valid), 1);
        ticks(1);
        chk("a_bv24", int'(bus.bit_valid), 0);
        ticks(103);
        pos_is("a_end", 1, 3, 31);
        ticks(1);
        chk("a_fs128", int'(bus.frame_start), 1);
        pos_is("a_wrap", 1, 0, 0);
        chk("a_err", int'(bus.cfg_err), 0);

        // Width change mid-frame is deferred to the next frame start.
        do_reset();
        setcfg(3, 1, 1, 1);
        tick(3);
        chk("b_vwr16", int'(bus.valid_word_width_real), 16);
        ticks(64);
        pos_is("b_slot2", 1, 2, 0);
        bus.valid_word_width = 3'd3;
        ticks(63);
        chk("b_vwr_hold", int'(bus.valid_word_width_real), 16);
        ticks(1);
        chk("b_fs", int'(bus.frame_start), 1);
        chk("b_vwr24", int'(bus.valid_word_width_real), 24);

        // Enable dropped mid-frame: frame still runs to its end.
        do_reset();
        setcfg(3, 1, 3, 1);
        tick(3);
        ticks(32);
        pos_is("c_slot1", 1, 1, 0);
        bus.enable = 1'b0;
        ticks(95);
        pos_is("c_last", 1, 3, 31);
        ticks(1);
        pos_is("c_idle", 0, 0, 0);
        chk("c_fs", int'(bus.frame_start), 0);

        // Muted width: counters run, no valid bits.
        do_reset();
        setcfg(1, 0, 0, 1);
        tick(3);
        chk("d_active", int'(bus.active), 1);
        chk("d_vwr", int'(bus.valid_word_width_real), 0);
        ticks(40);
        chk("d_bv", int'(bus.bit_valid), 0);
        chk("d_wl", int'(bus.word_last), 0);

        // 32-bit width into a 16-bit slot clamps and flags; one-slot frames.
        do_reset();
        setcfg(0, 0, 4, 1);
        tick(3);
        chk("e_vwr", int'(bus.valid_word_width_real), 16);
        chk("e_err", int'(bus.cfg_err), 1);
        ticks(15);
        chk("e_bv15", int'(bus.bit_valid), 1);
        chk("e_wl15", int'(bus.word_last), 1);
        ticks(1);
        chk("e_fs16", int'(bus.frame_start), 1);
        pos_is("e_wrap", 1, 0, 0);

        // Asynchronous reset mid-frame, then restart.
        setcfg(3, 1, 3, 1);
        ticks(15);
        ticks(1 + 64 + 7);
        pos_is("f_pre", 1, 2, 7);
        #3 rst = 1'b1;
        #1;
        pos_is("f_rst", 0, 0, 0);
        chk("f_bv",  int'(bus.bit_valid), 0);
        chk("f_vwr", int'(bus.valid_word_width_real), 0);
        chk("f_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk("f_fs", int'(bus.frame_start), 1);
        pos_is("f_restart", 1, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) bus.enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 3) == 0) bus.ch_num = CH_W'($urandom);
                else bus.ch_num = CH_W'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 29) == 0) bus.slot_width_sel = 1'($urandom);
            if ($urandom_range(0, 19) == 0) bus.valid_word_width = 3'($urandom_range(0, 7));
            tick($urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
